// File: rtl/nco_sweep_controller.sv
// nco_sweep_controller
// Steps the NCO phase increment from a start value to a stop value in fixed
// steps. Each value is held for cfg_dwell+1 cycles. A sweep runs once or
// repeats until aborted.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   cfg_valid/cfg_ready   sweep request handshake (ready is combinational)
//   cfg_start_inc         signed first increment
//   cfg_stop_inc          signed final increment
//   cfg_step              unsigned step magnitude (0 is used as 1)
//   cfg_dwell             hold length minus one, in cycles
//   cfg_repeat            1 = restart from start after reaching stop
//   abort                 end the sweep on the next edge, without a pulse
//   phase_inc             registered signed increment to the NCO
//   busy                  sweep in progress
//   done                  one-cycle pulse when a single-shot sweep completes
//   sweep_wrap            one-cycle pulse when a repeating sweep restarts
module nco_sweep_controller #(
    parameter int INC_WIDTH   = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [INC_WIDTH-1:0]   cfg_start_inc,
    input  logic [INC_WIDTH-1:0]   cfg_stop_inc,
    input  logic [INC_WIDTH-1:0]   cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_repeat,
    input  logic                   abort,
    output logic [INC_WIDTH-1:0]   phase_inc,
    output logic                   busy,
    output logic                   done,
    output logic                   sweep_wrap
);

    // The step is an unsigned magnitude as wide as the increment, so a
    // signed current value plus/minus the step needs two extra bits to be
    // wrap-free.
    localparam int XW = INC_WIDTH + 2;

    typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

    state_t                 r_state, w_state_nx;
    logic [INC_WIDTH-1:0]   r_phase, w_phase_nx;
    logic [DWELL_WIDTH-1:0] r_cnt, w_cnt_nx;
    logic                   r_busy, w_busy_nx;
    logic                   r_done, w_done_nx;
    logic                   r_wrap, w_wrap_nx;
    logic                   w_load;

    // Parameters latched at acceptance; constant for the whole sweep.
    logic [INC_WIDTH-1:0]   r_start, r_stop, r_step;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic                   r_repeat, r_up;

    logic signed [XW-1:0]   w_cur_x, w_stop_x, w_step_x, w_sum, w_diff;
    logic [INC_WIDTH-1:0]   w_next;

    assign cfg_ready = (r_state == IDLE) && !abort;
    assign w_load    = (r_state == IDLE) && cfg_valid && !abort;

    assign w_cur_x  = $signed({{2{r_phase[INC_WIDTH-1]}}, r_phase});
    assign w_stop_x = $signed({{2{r_stop[INC_WIDTH-1]}}, r_stop});
    assign w_step_x = $signed({2'b00, r_step});
    assign w_sum    = w_cur_x + w_step_x;
    assign w_diff   = w_cur_x - w_step_x;

    // Clamp to stop when the step would overshoot it.
    always_comb begin
        w_next = r_stop;
        if (r_up) begin
            if (w_sum <= w_stop_x) w_next = w_sum[INC_WIDTH-1:0];
        end else begin
            if (w_diff >= w_stop_x) w_next = w_diff[INC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start  <= '0;
            r_stop   <= '0;
            r_step   <= '0;
            r_dwell  <= '0;
            r_repeat <= 1'b0;
            r_up     <= 1'b1;
        end else if (w_load) begin
            r_start  <= cfg_start_inc;
            r_stop   <= cfg_stop_inc;
            r_step   <= (cfg_step == '0) ? INC_WIDTH'(1) : cfg_step;
            r_dwell  <= cfg_dwell;
            r_repeat <= cfg_repeat;
            r_up     <= $signed(cfg_stop_inc) >= $signed(cfg_start_inc);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_cnt_nx   = r_cnt;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_wrap_nx  = 1'b0;
        if (abort) begin
            w_state_nx = IDLE;
            w_phase_nx = '0;
            w_busy_nx  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_valid) begin
                        w_state_nx = DWELL;
                        w_phase_nx = cfg_start_inc;
                        w_cnt_nx   = cfg_dwell;
                        w_busy_nx  = 1'b1;
                    end
                end
                DWELL: begin
                    if (r_cnt != '0) begin
                        w_cnt_nx = r_cnt - DWELL_WIDTH'(1);
                    end else if (r_phase != r_stop) begin
                        w_phase_nx = w_next;
                        w_cnt_nx   = r_dwell;
                    end else if (r_repeat) begin
                        w_phase_nx = r_start;
                        w_cnt_nx   = r_dwell;
                        w_wrap_nx  = 1'b1;
                    end else begin
                        // phase_inc keeps the stop value after completion
                        w_state_nx = IDLE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_wrap  <= w_wrap_nx;
        end
    end

    assign phase_inc  = r_phase;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sweep_wrap = r_wrap;

endmodule
